z80_bus_responder: RTL

Synthesizable memory/IO responder for the TV80 core's Z80-style bus. It is the target side of the bus cycles the CPU initiates. It decodes opcode fetch, memory read/write, IO read/write and interrupt-acknowledge cycles. It holds a byte-wide RAM, inserts programmable wait states, and returns read data on `di`. It replaces the behavioural `mem[]` array in instruction-level benches and gives them a sideband preload port and an M1 counter for cycle-accurate checking.

---
 rtl/z80_bus_responder.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/z80_bus_responder.sv
// z80_bus_responder
//   Target-side responder for the TV80 Z80-style bus. Decodes opcode fetch,
//   memory read/write, IO read/write and interrupt-acknowledge cycles, serves
//   them from a byte-wide RAM with programmable wait states, and exposes a
//   preload port plus an opcode-fetch counter for cycle-accurate benches.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   a, dout                      CPU address bus and write data
//   m1_n, mreq_n, iorq_n,
//   rd_n, wr_n, rfsh_n           CPU bus strobes (active-low)
//   di, wait_n                   read data and wait request back to the CPU
//   io_in, io_out, io_strobe     IO_PORT read value, last written byte, write pulse
//   load_en, load_addr, load_data  sideband RAM preload
//   m1_count                     opcode fetches since reset (wrapping)
//   busy                         a bus cycle is being serviced
module z80_bus_responder #(
   parameter int unsigned ADDR_W      = 12,
   parameter int unsigned WAIT_STATES = 0,
   parameter int unsigned M1_EXTRA    = 0,
   parameter logic [7:0]  IO_PORT     = 8'h10,
   parameter logic [7:0]  INT_VECTOR  = 8'hFF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [15:0]       a,
   input  logic [7:0]        dout,
   input  logic              m1_n,
   input  logic              mreq_n,
   input  logic              iorq_n,
   input  logic              rd_n,
   input  logic              wr_n,
   input  logic              rfsh_n,
   output logic [7:0]        di,
   output logic              wait_n,
   input  logic [7:0]        io_in,
   output logic [7:0]        io_out,
   output logic              io_strobe,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [7:0]        load_data,
   output logic [15:0]       m1_count,
   output logic              busy
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_HOLD} state_t;
   typedef enum logic [2:0] {C_INTA, C_MEM_RD, C_MEM_WR, C_IO_RD, C_IO_WR} cyc_t;

   localparam logic [3:0] WS_BASE  = 4'(WAIT_STATES);
   localparam logic [3:0] WS_FETCH = 4'(WAIT_STATES + M1_EXTRA);

   logic [7:0]        mem [0:(1 << ADDR_W) - 1];

   state_t            state;
   cyc_t              cyc_q;
   logic [ADDR_W-1:0] addr_q;
   logic              fetch_q;
   logic              io_hit_q;
   logic [3:0]        cnt;

   logic              det;
   cyc_t              det_cyc;
   logic              det_fetch;
   logic [3:0]        det_waits;
   logic              strobe_live;
   logic              bus_idle;
   logic              bus_we;
   logic              unused_bits;

   // Upper address bits alias; only the reduction keeps them referenced.
   assign unused_bits = ^a;

   // Cycle classification, highest priority first.
   always_comb begin
      det     = 1'b1;
      det_cyc = C_INTA;
      if (!iorq_n && !m1_n)                 det_cyc = C_INTA;
      else if (!mreq_n && !rd_n && rfsh_n)  det_cyc = C_MEM_RD;
      else if (!mreq_n && !wr_n)            det_cyc = C_MEM_WR;
      else if (!iorq_n && !rd_n)            det_cyc = C_IO_RD;
      else if (!iorq_n && !wr_n)            det_cyc = C_IO_WR;
      else                                  det = 1'b0;
   end

   assign det_fetch = det && (det_cyc == C_MEM_RD) && !m1_n;
   assign det_waits = det_fetch ? WS_FETCH : WS_BASE;

   // The strobes that qualified the latched cycle must still be asserted,
   // otherwise the CPU has abandoned it.
   always_comb begin
      strobe_live = 1'b0;
      case (cyc_q)
         C_INTA:   strobe_live = !iorq_n && !m1_n;
         C_MEM_RD: strobe_live = !mreq_n && !rd_n;
         C_MEM_WR: strobe_live = !mreq_n && !wr_n;
         C_IO_RD:  strobe_live = !iorq_n && !rd_n;
         C_IO_WR:  strobe_live = !iorq_n && !wr_n;
         default:  strobe_live = 1'b0;
      endcase
   end

   assign bus_idle = mreq_n && iorq_n && rd_n && wr_n;
   assign bus_we   = (state == S_ACCESS) && (cyc_q == C_MEM_WR);

   // Preload and bus write are independent ports; the bus write is issued
   // last so it takes the location when both target the same address.
   always_ff @(posedge clk) begin
      if (load_en) mem[load_addr] <= load_data;
      if (bus_we)  mem[addr_q]    <= dout;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         cyc_q     <= C_INTA;
         addr_q    <= '0;
         fetch_q   <= 1'b0;
         io_hit_q  <= 1'b0;
         cnt       <= '0;
         di        <= 8'hFF;
         wait_n    <= 1'b1;
         io_out    <= '0;
         io_strobe <= 1'b0;
         m1_count  <= '0;
         busy      <= 1'b0;
      end else begin
         io_strobe <= 1'b0;
         case (state)
            S_IDLE: begin
               if (det) begin
                  cyc_q    <= det_cyc;
                  addr_q   <= a[ADDR_W-1:0];
                  fetch_q  <= det_fetch;
                  io_hit_q <= (a[7:0] == IO_PORT);
                  cnt      <= det_waits;
                  busy     <= 1'b1;
                  state    <= (det_waits != '0) ? S_WAIT : S_ACCESS;
               end
            end
            S_WAIT: begin
               if (!strobe_live) begin
                  state  <= S_IDLE;
                  busy   <= 1'b0;
                  wait_n <= 1'b1;
                  di     <= 8'hFF;
               end else begin
                  // wait_n is registered, so leaving on count 1 gives exactly
                  // cnt low cycles before the access edge.
                  wait_n <= 1'b0;
                  cnt    <= cnt - 4'd1;
                  if (cnt == 4'd1) state <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               wait_n <= 1'b1;
               case (cyc_q)
                  C_MEM_RD: di <= mem[addr_q];
                  C_IO_RD:  di <= io_hit_q ? io_in : 8'hFF;
                  C_IO_WR: begin
                     if (io_hit_q) begin
                        io_out    <= dout;
                        io_strobe <= 1'b1;
                     end
                  end
                  C_INTA:   di <= INT_VECTOR;
                  default:  ;
               endcase
               if (fetch_q) m1_count <= m1_count + 16'd1;
               state <= S_HOLD;
            end
            S_HOLD: begin
               if (bus_idle) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  di    <= 8'hFF;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
